// File: rtl/serial_rx194_pkg.sv
// serial_rx194_pkg: shared types and constants for the serial frame receiver.
//   state_e        receiver FSM states (IDLE, DATA, STOP)
//   DIR_*          bit-order encodings for the DIR input
//   LINE_IDLE      idle serial line level
//   START_BIT      level that marks a start bit
//   STOP_BIT       level expected in the stop-bit slot
package serial_rx194_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      STOP = 2'd2
   } state_e;

   localparam logic DIR_MSB_FIRST = 1'b0;
   localparam logic DIR_LSB_FIRST = 1'b1;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/serial_rx194_rx_shift_core.sv
// rx_shift_core: direction-selectable serial-in shift register with a bit counter.
//   clk_i    clock, rising edge
//   rst_ni   asynchronous active-low reset
//   clr_i    clear the bit counter (start of a new frame)
//   shift_i  shift sin_i into the register and advance the counter
//   dir_i    bit order: DIR_MSB_FIRST shifts left, DIR_LSB_FIRST shifts right
//   sin_i    serial data bit
//   shreg_o  current shift register contents
//   last_o   high while the counter points at the final data bit
module rx_shift_core
   import serial_rx194_pkg::*;
#(
   parameter int unsigned Width = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             shift_i,
   input  logic             dir_i,
   input  logic             sin_i,
   output logic [Width-1:0] shreg_o,
   output logic             last_o
);

   localparam int unsigned CntW = $clog2(Width);

   logic [Width-1:0] shreg_q, shreg_d;
   logic [CntW-1:0]  cnt_q, cnt_d;

   assign last_o  = (cnt_q == CntW'(Width - 1));
   assign shreg_o = shreg_q;

   always_comb begin
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (shift_i) begin
         if (dir_i == DIR_LSB_FIRST) begin
            shreg_d = {sin_i, shreg_q[Width-1:1]};
         end else begin
            shreg_d = {shreg_q[Width-2:0], sin_i};
         end
         // Hold on the last bit so the counter never wraps inside a frame.
         if (!last_o) begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         shreg_q <= '0;
         cnt_q   <= '0;
      end else begin
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/serial_rx194.sv
// serial_rx194: serial frame receiver (start bit, WIDTH data bits, stop bit).
//   CP    clock, rising edge
//   CR    asynchronous active-low clear
//   SEN   bit strobe; SIN is sampled only when SEN=1
//   SIN   serial data, idle level 1
//   DIR   bit order, latched at the start bit (0 = MSB first, 1 = LSB first)
//   Q     last correctly framed word
//   QV    one-cycle pulse when Q is updated
//   FERR  one-cycle pulse on a stop-bit error
//   BUSY  high from the accepted start bit until the stop bit is sampled
module serial_rx194
   import serial_rx194_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             CP,
   input  logic             CR,
   input  logic             SEN,
   input  logic             SIN,
   input  logic             DIR,
   output logic [WIDTH-1:0] Q,
   output logic             QV,
   output logic             FERR,
   output logic             BUSY
);

   state_e           state_q, state_d;
   logic             dir_q, dir_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             qv_q, qv_d;
   logic             ferr_q, ferr_d;
   logic             busy_q, busy_d;

   logic             start;
   logic             shift;
   logic             last;
   logic [WIDTH-1:0] shreg;

   assign start = (state_q == IDLE) && SEN && (SIN == START_BIT);
   assign shift = (state_q == DATA) && SEN;

   rx_shift_core #(
      .Width (WIDTH)
   ) u_core (
      .clk_i   (CP),
      .rst_ni  (CR),
      .clr_i   (start),
      .shift_i (shift),
      .dir_i   (dir_q),
      .sin_i   (SIN),
      .shreg_o (shreg),
      .last_o  (last)
   );

   // State register.
   always_ff @(posedge CP or negedge CR) begin
      if (!CR) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (start) state_d = DATA;
         DATA: if (SEN && last) state_d = STOP;
         // A 0 in the stop slot is an error, never a new start bit.
         STOP: if (SEN) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output next-state logic; every output is registered.
   always_comb begin
      dir_d  = dir_q;
      q_d    = q_q;
      qv_d   = 1'b0;
      ferr_d = 1'b0;
      busy_d = busy_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               dir_d  = DIR;
               busy_d = 1'b1;
            end
         end
         DATA: ;
         STOP: begin
            if (SEN) begin
               busy_d = 1'b0;
               if (SIN == STOP_BIT) begin
                  q_d  = shreg;
                  qv_d = 1'b1;
               end else begin
                  ferr_d = 1'b1;
               end
            end
         end
         default: busy_d = 1'b0;
      endcase
   end

   always_ff @(posedge CP or negedge CR) begin
      if (!CR) begin
         dir_q  <= DIR_MSB_FIRST;
         q_q    <= '0;
         qv_q   <= 1'b0;
         ferr_q <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         dir_q  <= dir_d;
         q_q    <= q_d;
         qv_q   <= qv_d;
         ferr_q <= ferr_d;
         busy_q <= busy_d;
      end
   end

   assign Q    = q_q;
   assign QV   = qv_q;
   assign FERR = ferr_q;
   assign BUSY = busy_q;

endmodule
